// File: rtl/hub75_pkg.sv
// Shared constants and state type for the HUB75 panel receiver and the driver's bench.
package hub75_pkg;

    localparam int ROWS_DEF        = 32;
    localparam int COLS_DEF        = 64;
    localparam int DW_DEF          = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int ROW_W_DEF       = $clog2(ROWS_DEF);
    localparam int COL_W_DEF       = $clog2(COLS_DEF);
    localparam int RD_ROW_W_DEF    = $clog2(2 * ROWS_DEF);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        COPY = 1'b1
    } rx_state_t;

endpackage

// File: rtl/hub75_input_sync.sv
// Aligned multi-stage synchronizer for the panel inputs with rising-edge detect
// on the shift clock and the latch strobe.
module hub75_input_sync
    import hub75_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int W           = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dclk_i,
    input  logic         latch_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         dclk_rise_o,
    output logic         latch_rise_o
);

    logic [SYNC_STAGES-1:0][W+1:0] stage_q;
    logic [1:0]                    prev_q;

    // Strobes travel in the same pipeline as data so they stay cycle-aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
            prev_q  <= 2'b00;
        end else begin
            stage_q[0] <= {data_i, latch_i, dclk_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[SYNC_STAGES-1][1:0];
        end
    end

    assign data_o       = stage_q[SYNC_STAGES-1][W+1:2];
    assign dclk_rise_o  = stage_q[SYNC_STAGES-1][0] & ~prev_q[0];
    assign latch_rise_o = stage_q[SYNC_STAGES-1][1] & ~prev_q[1];

endmodule

// File: rtl/hub75_panel_receiver.sv
// Panel-side HUB75 receiver: shifts columns in, latches rows into a hold buffer,
// copies them into a frame memory and flags protocol violations.
module hub75_panel_receiver
    import hub75_pkg::*;
#(
    parameter int ROWS        = ROWS_DEF,
    parameter int COLS        = COLS_DEF,
    parameter int DW          = DW_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      display_clk,
    input  logic                      latch,
    input  logic                      display_oe,
    input  logic [$clog2(ROWS)-1:0]   row_addr,
    input  logic [$clog2(COLS)-1:0]   col_addr,
    input  logic [DW-1:0]             dout_a,
    input  logic [DW-1:0]             dout_b,
    input  logic [$clog2(2*ROWS)-1:0] rd_row,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic [DW-1:0]             rd_data,
    output logic                      row_strobe,
    output logic [$clog2(ROWS)-1:0]   row_index,
    output logic                      frame_strobe,
    output logic [$clog2(COLS):0]     shift_count,
    output logic                      err_shift_len,
    output logic                      err_latch_oe,
    output logic                      err_col,
    output logic                      err_overrun,
    input  logic                      err_clr
);

    localparam int RW  = $clog2(ROWS);
    localparam int CW  = $clog2(COLS);
    localparam int RDW = $clog2(2 * ROWS);
    localparam int SCW = CW + 1;
    localparam int PW  = 1 + RW + CW + 2 * DW;

    logic [PW-1:0]  pins_s;
    logic [PW-1:0]  synced_s;
    logic           dclk_rise_s;
    logic           latch_rise_s;
    logic           oe_s;
    logic [RW-1:0]  row_addr_s;
    logic [CW-1:0]  col_addr_s;
    logic [DW-1:0]  dout_a_s;
    logic [DW-1:0]  dout_b_s;

    rx_state_t      state_q, state_d;
    logic [SCW-1:0] shift_count_q, shift_count_d;
    logic [SCW-1:0] copy_col_q, copy_col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [RW-1:0]  row_index_q, row_index_d;
    logic           row_strobe_q, row_strobe_d;
    logic           frame_strobe_q, frame_strobe_d;
    logic           err_len_q, err_len_d;
    logic           err_oe_q, err_oe_d;
    logic           err_col_q, err_col_d;
    logic           err_ovr_q, err_ovr_d;
    logic [DW-1:0]  rd_data_q;

    logic [COLS-1:0][DW-1:0] shift_a_q, shift_b_q;
    logic [COLS-1:0][DW-1:0] hold_a_q, hold_b_q;
    logic [2*DW-1:0]         mem_q [ROWS][COLS];

    logic           latch_acc_s;
    logic [SCW-1:0] eff_count_s;
    logic           shift_wr_s;
    logic           mem_we_s;
    logic           rd_upper_s;
    logic [RW-1:0]  rd_sel_row_s;
    logic [2*DW-1:0] rd_word_s;

    assign pins_s = {dout_b, dout_a, col_addr, row_addr, display_oe};

    hub75_input_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .W           (PW)
    ) u_sync (
        .clk          (clk),
        .rst          (rst),
        .dclk_i       (display_clk),
        .latch_i      (latch),
        .data_i       (pins_s),
        .data_o       (synced_s),
        .dclk_rise_o  (dclk_rise_s),
        .latch_rise_o (latch_rise_s)
    );

    assign oe_s       = synced_s[0];
    assign row_addr_s = synced_s[1 +: RW];
    assign col_addr_s = synced_s[1+RW +: CW];
    assign dout_a_s   = synced_s[1+RW+CW +: DW];
    assign dout_b_s   = synced_s[1+RW+CW+DW +: DW];

    // An accepted latch restarts the count, so a same-cycle shift lands in column 0.
    assign latch_acc_s = latch_rise_s && (state_q == IDLE);
    assign eff_count_s = latch_acc_s ? '0 : shift_count_q;
    assign shift_wr_s  = dclk_rise_s && (eff_count_s < SCW'(COLS));

    // Shift counter: saturates at COLS, extra shifts are dropped.
    always_comb begin
        shift_count_d = eff_count_s;
        if (shift_wr_s) begin
            shift_count_d = eff_count_s + SCW'(1);
        end else begin
            shift_count_d = eff_count_s;
        end
    end

    // Row copy sequencer: snapshot on latch, one column per cycle, then strobe.
    always_comb begin
        state_d        = state_q;
        copy_col_d     = copy_col_q;
        row_d          = row_q;
        row_index_d    = row_index_q;
        row_strobe_d   = 1'b0;
        frame_strobe_d = 1'b0;
        mem_we_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (latch_rise_s) begin
                    state_d    = COPY;
                    copy_col_d = '0;
                    row_d      = row_addr_s;
                end else begin
                    state_d = IDLE;
                end
            end
            COPY: begin
                if (copy_col_q == SCW'(COLS)) begin
                    state_d        = IDLE;
                    row_strobe_d   = 1'b1;
                    frame_strobe_d = (row_q == RW'(ROWS - 1));
                    row_index_d    = row_q;
                end else begin
                    mem_we_s   = 1'b1;
                    copy_col_d = copy_col_q + SCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky errors: a fresh event outranks err_clr in the same cycle.
    always_comb begin
        err_len_d = err_len_q && !err_clr;
        err_oe_d  = err_oe_q && !err_clr;
        err_col_d = err_col_q && !err_clr;
        err_ovr_d = err_ovr_q && !err_clr;
        if ((dclk_rise_s && !shift_wr_s) ||
            (latch_rise_s && (shift_count_q != SCW'(COLS)))) begin
            err_len_d = 1'b1;
        end else begin
            err_len_d = err_len_d;
        end
        if (latch_rise_s && !oe_s) begin
            err_oe_d = 1'b1;
        end else begin
            err_oe_d = err_oe_d;
        end
        if (dclk_rise_s && ({1'b0, col_addr_s} != eff_count_s)) begin
            err_col_d = 1'b1;
        end else begin
            err_col_d = err_col_d;
        end
        if (latch_rise_s && (state_q == COPY)) begin
            err_ovr_d = 1'b1;
        end else begin
            err_ovr_d = err_ovr_d;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            shift_count_q  <= '0;
            copy_col_q     <= '0;
            row_q          <= '0;
            row_index_q    <= '0;
            row_strobe_q   <= 1'b0;
            frame_strobe_q <= 1'b0;
            err_len_q      <= 1'b0;
            err_oe_q       <= 1'b0;
            err_col_q      <= 1'b0;
            err_ovr_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_count_q  <= shift_count_d;
            copy_col_q     <= copy_col_d;
            row_q          <= row_d;
            row_index_q    <= row_index_d;
            row_strobe_q   <= row_strobe_d;
            frame_strobe_q <= frame_strobe_d;
            err_len_q      <= err_len_d;
            err_oe_q       <= err_oe_d;
            err_col_q      <= err_col_d;
            err_ovr_q      <= err_ovr_d;
        end
    end

    // Shift and hold buffers; the hold snapshot sees pre-shift contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_a_q <= '0;
            shift_b_q <= '0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
        end else begin
            if (shift_wr_s) begin
                shift_a_q[eff_count_s[CW-1:0]] <= dout_a_s;
                shift_b_q[eff_count_s[CW-1:0]] <= dout_b_s;
            end
            if (latch_acc_s) begin
                hold_a_q <= shift_a_q;
                hold_b_q <= shift_b_q;
            end
        end
    end

    // Frame memory write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[row_q][copy_col_q[CW-1:0]] <= {hold_b_q[copy_col_q[CW-1:0]],
                                                 hold_a_q[copy_col_q[CW-1:0]]};
        end
    end

    assign rd_upper_s   = (rd_row < RDW'(ROWS));
    assign rd_sel_row_s = rd_upper_s ? RW'(rd_row) : RW'(rd_row - RDW'(ROWS));
    assign rd_word_s    = mem_q[rd_sel_row_s][rd_col];

    // Registered readout; a same-cycle write is not visible until the next read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_upper_s) begin
            rd_data_q <= rd_word_s[DW-1:0];
        end else begin
            rd_data_q <= rd_word_s[2*DW-1:DW];
        end
    end

    assign rd_data       = rd_data_q;
    assign row_strobe    = row_strobe_q;
    assign row_index     = row_index_q;
    assign frame_strobe  = frame_strobe_q;
    assign shift_count   = shift_count_q;
    assign err_shift_len = err_len_q;
    assign err_latch_oe  = err_oe_q;
    assign err_col       = err_col_q;
    assign err_overrun   = err_ovr_q;

endmodule

// File: tb/tb_hub75_panel_receiver.sv
// Bench for hub75_panel_receiver: pin-level HUB75 stimulus against a
// transaction-level model of shift buffer, frame image and error flags.
module tb_hub75_panel_receiver;

    localparam int ROWS = 32;
    localparam int COLS = 64;
    localparam int S    = 2;
    localparam int LAT  = S + 1 + COLS + 1;

    logic clk = 1'b0, rst = 1'b1;
    logic display_clk = 1'b0, latch = 1'b0, display_oe = 1'b1, err_clr = 1'b0;
    logic [4:0] row_addr = '0;
    logic [5:0] col_addr = '0;
    logic [3:0] dout_a = '0, dout_b = '0;
    logic [5:0] rd_row = '0, rd_col = '0;
    logic [3:0] rd_data;
    logic       row_strobe, frame_strobe;
    logic [4:0] row_index;
    logic [6:0] shift_count;
    logic       err_shift_len, err_latch_oe, err_col, err_overrun;

    always #5 clk = ~clk;

    hub75_panel_receiver dut (
        .clk(clk), .rst(rst), .display_clk(display_clk), .latch(latch),
        .display_oe(display_oe), .row_addr(row_addr), .col_addr(col_addr),
        .dout_a(dout_a), .dout_b(dout_b), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .row_strobe(row_strobe), .row_index(row_index),
        .frame_strobe(frame_strobe), .shift_count(shift_count),
        .err_shift_len(err_shift_len), .err_latch_oe(err_latch_oe),
        .err_col(err_col), .err_overrun(err_overrun), .err_clr(err_clr)
    );

    int checks = 0, failures = 0;
    int cyc = 0, lat_cyc = 0;
    int strobe_cnt = 0, frame_cnt = 0, last_strobe_cyc = 0, last_row_idx = 0;

    // Reference model state
    logic [3:0] m_sa [COLS];
    logic [3:0] m_sb [COLS];
    logic [3:0] m_mem [2*ROWS][COLS];
    bit         m_known [2*ROWS];
    int         m_cnt = 0, m_last_acc = -1000, exp_strobes = 0;
    bit         m_e_len = 0, m_e_oe = 0, m_e_col = 0, m_e_ovr = 0;

    typedef struct { int row; int col; logic [3:0] exp; } rd_vec_t;
    rd_vec_t t1_vec [6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && row_strobe) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            last_row_idx    = row_index;
            if (frame_strobe) frame_cnt++;
            chk("frame_strobe_vs_row", frame_strobe, (row_index == 5'd31));
        end else if (rst && frame_strobe) begin
            chk("frame_strobe_alone", frame_strobe, 1'b0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic shift_col(input logic [5:0] ca, input logic [3:0] a, input logic [3:0] b);
        col_addr = ca; dout_a = a; dout_b = b;
        tick(3);
        display_clk = 1'b1;
        if (int'(ca) != m_cnt) m_e_col = 1;
        if (m_cnt < COLS) begin
            m_sa[m_cnt] = a; m_sb[m_cnt] = b; m_cnt++;
        end else begin
            m_e_len = 1;
        end
        tick(3);
        display_clk = 1'b0;
    endtask

    task automatic shift_random_row();
        for (int c = 0; c < COLS; c++) shift_col(6'(c), 4'($urandom), 4'($urandom));
    endtask

    task automatic latch_row(input int row, input logic oe);
        row_addr = 5'(row); display_oe = oe; latch = 1'b1;
        lat_cyc = cyc;
        if (m_cnt != COLS) m_e_len = 1;
        if (!oe) m_e_oe = 1;
        if (cyc - m_last_acc <= COLS + 1) begin
            m_e_ovr = 1;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                m_mem[row][c] = m_sa[c];
                m_mem[row+ROWS][c] = m_sb[c];
            end
            m_known[row] = 1; m_known[row+ROWS] = 1;
            m_cnt = 0; m_last_acc = cyc; exp_strobes++;
        end
        tick(3);
        latch = 1'b0; display_oe = 1'b1;
        tick(3);
    endtask

    task automatic wait_strobes(input int n, input string name);
        int budget = 200;
        while (strobe_cnt < n && budget > 0) begin
            tick(1);
            budget--;
        end
        chk(name, strobe_cnt, n);
        tick(2);
    endtask

    task automatic check_errs(input string tag);
        tick(2);
        chk({tag, ".err_shift_len"}, err_shift_len, m_e_len);
        chk({tag, ".err_latch_oe"}, err_latch_oe, m_e_oe);
        chk({tag, ".err_col"}, err_col, m_e_col);
        chk({tag, ".err_overrun"}, err_overrun, m_e_ovr);
        chk({tag, ".shift_count"}, shift_count, m_cnt);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_e_len = 0; m_e_oe = 0; m_e_col = 0; m_e_ovr = 0;
    endtask

    task automatic check_pix(input int r, input int c, input logic [3:0] exp, input string name);
        rd_row = 6'(r); rd_col = 6'(c);
        tick(1);
        chk(name, rd_data, exp);
    endtask

    task automatic random_reads(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            int r = $urandom_range(0, 2*ROWS-1);
            int c = $urandom_range(0, COLS-1);
            if (m_known[r]) check_pix(r, c, m_mem[r][c], name);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, fbase;
        t1_vec[0] = '{5, 10, 4'hA};
        t1_vec[1] = '{37, 10, 4'h5};
        t1_vec[2] = '{5, 0, 4'h0};
        t1_vec[3] = '{37, 0, 4'hF};
        t1_vec[4] = '{5, 63, 4'hF};
        t1_vec[5] = '{37, 63, 4'h0};
        for (int r = 0; r < 2*ROWS; r++) m_known[r] = 0;
        for (int c = 0; c < COLS; c++) begin m_sa[c] = 4'h0; m_sb[c] = 4'h0; end

        // Reset state
        #1 rst = 1'b0;
        #2;
        chk("rst.rd_data", rd_data, 4'h0);
        chk("rst.row_strobe", row_strobe, 1'b0);
        chk("rst.row_index", row_index, 5'd0);
        chk("rst.frame_strobe", frame_strobe, 1'b0);
        chk("rst.shift_count", shift_count, 7'd0);
        chk("rst.errors", {err_shift_len, err_latch_oe, err_col, err_overrun}, 4'b0000);
        tick(2);
        rst = 1'b1;
        tick(3);

        // Row 5 with column-derived pattern, latency and table readout
        for (int c = 0; c < COLS; c++) shift_col(6'(c), 4'(c), ~4'(c));
        check_errs("t1_pre");
        base = strobe_cnt;
        latch_row(5, 1'b1);
        base = base + 1;
        wait_strobes(base, "t1.strobe_count");
        chk("t1.latency", last_strobe_cyc - lat_cyc, LAT);
        chk("t1.row_index", last_row_idx, 5);
        chk("t1.no_frame", frame_cnt, 0);
        check_errs("t1");
        for (int i = 0; i < 6; i++) check_pix(t1_vec[i].row, t1_vec[i].col, t1_vec[i].exp, "t1.readout");

        // Full random frame
        base = strobe_cnt; fbase = frame_cnt;
        for (int r = 0; r < ROWS; r++) begin
            shift_random_row();
            latch_row(r, 1'b1);
        end
        wait_strobes(base + ROWS, "frame.strobe_count");
        chk("frame.frame_count", frame_cnt - fbase, 1);
        chk("frame.last_row", last_row_idx, 31);
        check_errs("frame");
        random_reads(48, "frame.readout");

        // Short row, then over-long row
        for (int c = 0; c < COLS-1; c++) shift_col(6'(c), 4'($urandom), 4'($urandom));
        latch_row(7, 1'b1);
        check_errs("short");
        for (int c = 0; c <= COLS; c++) begin
            if (c == 0) shift_col(6'd0, 4'h3, 4'h9);
            else if (c == COLS) shift_col(6'(c), 4'hC, 4'h6);
            else shift_col(6'(c), 4'($urandom), 4'($urandom));
        end
        check_errs("long");
        base = strobe_cnt;
        latch_row(8, 1'b1);
        wait_strobes(base + 1, "long.strobe");
        check_pix(8, 0, 4'h3, "long.col0_a");
        check_pix(40, 0, 4'h9, "long.col0_b");
        check_pix(7, 63, m_mem[7][63], "short.stale_col63");
        clear_errs();
        check_errs("clr");

        // Latch while LEDs lit, then stuck column address
        shift_random_row();
        base = strobe_cnt;
        latch_row(9, 1'b0);
        wait_strobes(base + 1, "oe.strobe");
        check_errs("oe");
        clear_errs();
        shift_col(6'd0, 4'h1, 4'h2);
        check_errs("col.first");
        shift_col(6'd0, 4'h4, 4'h8);
        check_errs("col.second");
        for (int c = 2; c < COLS; c++) shift_col(6'd0, 4'($urandom), 4'($urandom));
        base = strobe_cnt;
        latch_row(10, 1'b1);
        wait_strobes(base + 1, "col.strobe");
        check_pix(10, 1, 4'h4, "col.readout");
        clear_errs();

        // Second latch 10 clk after the first
        shift_random_row();
        base = strobe_cnt;
        latch_row(12, 1'b1);
        tick(4);
        latch_row(13, 1'b1);
        wait_strobes(base + 1, "ovr.strobe");
        tick(100);
        chk("ovr.single_strobe", strobe_cnt, base + 1);
        chk("ovr.row_index", last_row_idx, 12);
        check_errs("ovr");
        for (int c = 0; c < COLS; c += 9) begin
            check_pix(12, c, m_mem[12][c], "ovr.row12");
            check_pix(44, c, m_mem[44][c], "ovr.row44");
        end
        clear_errs();

        // Reset in the middle of a copy
        shift_random_row();
        base = strobe_cnt;
        latch_row(14, 1'b1);
        tick(24);
        rst = 1'b0;
        #1;
        chk("rstmid.row_strobe", row_strobe, 1'b0);
        chk("rstmid.row_index", row_index, 5'd0);
        chk("rstmid.frame_strobe", frame_strobe, 1'b0);
        chk("rstmid.shift_count", shift_count, 7'd0);
        chk("rstmid.rd_data", rd_data, 4'h0);
        chk("rstmid.errors", {err_shift_len, err_latch_oe, err_col, err_overrun}, 4'b0000);
        tick(3);
        rst = 1'b1;
        m_cnt = 0; m_last_acc = -1000; exp_strobes--;
        m_e_len = 0; m_e_oe = 0; m_e_col = 0; m_e_ovr = 0;
        m_known[14] = 0; m_known[46] = 0;
        for (int c = 0; c < COLS; c++) begin m_sa[c] = 4'h0; m_sb[c] = 4'h0; end
        tick(100);
        chk("rstmid.no_strobe", strobe_cnt, base);
        shift_random_row();
        latch_row(14, 1'b1);
        wait_strobes(base + 1, "rstmid.next_strobe");
        chk("rstmid.next_row", last_row_idx, 14);
        check_errs("rstmid.next");
        for (int c = 0; c < COLS; c += 7) begin
            check_pix(14, c, m_mem[14][c], "rstmid.row14");
            check_pix(46, c, m_mem[46][c], "rstmid.row46");
        end
        random_reads(24, "final.readout");
        chk("total_strobes", strobe_cnt, exp_strobes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
